// File: rtl/ascon_pack.sv
// ascon_pack: shared state type, scheduler FSM encoding, round constant and
// the three round layers (constant addition, substitution, linear diffusion)
// of the ASCON permutation.
//   type_state : 5 x 64-bit state. Element 4 is x0, the most significant word;
//                element 0 is x4. x2 is element 2 in either reading.
package ascon_pack;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned WORDS     = 5;
  localparam int unsigned ROUND_W   = 4;
  localparam int unsigned ROUND_MAX = 12;

  typedef logic [WORDS-1:0][WORD_W-1:0] type_state;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } type_perm_fsm;

  // c_r = ((0xF - r) << 4) | r
  function automatic logic [7:0] round_constant(input logic [ROUND_W-1:0] r);
    return {4'hF - r, r};
  endfunction

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned      n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Round constant goes into the low byte of x2.
  function automatic type_state add_constant(input type_state          s,
                                             input logic [ROUND_W-1:0] r);
    type_state o;
    o       = s;
    o[2][7:0] = s[2][7:0] ^ round_constant(r);
    return o;
  endfunction

  // Bit-sliced 5-bit S-box applied to all 64 columns at once.
  function automatic type_state sbox_layer(input type_state s);
    logic [WORD_W-1:0] x0, x1, x2, x3, x4;
    logic [WORD_W-1:0] t0, t1, t2, t3, t4;
    type_state         o;
    x0 = s[4] ^ s[0];
    x1 = s[3];
    x2 = s[2] ^ s[3];
    x3 = s[1];
    x4 = s[0] ^ s[1];
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    o[4] = x0;
    o[3] = x1;
    o[2] = x2;
    o[1] = x3;
    o[0] = x4;
    return o;
  endfunction

  function automatic type_state linear_layer(input type_state s);
    type_state o;
    o[4] = s[4] ^ rotr(s[4], 19) ^ rotr(s[4], 28);
    o[3] = s[3] ^ rotr(s[3], 61) ^ rotr(s[3], 39);
    o[2] = s[2] ^ rotr(s[2], 1)  ^ rotr(s[2], 6);
    o[1] = s[1] ^ rotr(s[1], 10) ^ rotr(s[1], 17);
    o[0] = s[0] ^ rotr(s[0], 7)  ^ rotr(s[0], 41);
    return o;
  endfunction

endpackage

// File: rtl/permutation_round.sv
// permutation_round: one combinational ASCON round.
//   state       : state before the round
//   round_index : round index r (0..11), selects the round constant
//   next_state  : state after constant addition, S-box and diffusion
module permutation_round
  import ascon_pack::*;
(
  input  type_state          state,
  input  logic [ROUND_W-1:0] round_index,
  output type_state          next_state
);

  type_state after_const;
  type_state after_sbox;

  assign after_const = add_constant(state, round_index);
  assign after_sbox  = sbox_layer(after_const);
  assign next_state  = linear_layer(after_sbox);

endmodule

// File: rtl/permutation_scheduler.sv
// permutation_scheduler: loads a 320-bit state and applies N ASCON rounds,
// one per clock, then pulses done_o for one cycle with the result on state_o.
//   clock_i  : clock, rising edge
//   reset_i  : synchronous active-high reset
//   start_i  : operation request, taken only while ready_o = 1
//   rounds_i : round count N (1..12; 0 or >12 runs 12 rounds)
//   state_i  : state loaded on an accepted start
//   ready_o  : idle, a start will be accepted
//   done_o   : one-cycle completion pulse
//   round_o  : round index applied at the next edge (meaningful in RUN)
//   state_o  : state register contents
module permutation_scheduler
  import ascon_pack::*;
(
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [ROUND_W-1:0] rounds_i,
  input  type_state          state_i,
  output logic               ready_o,
  output logic               done_o,
  output logic [ROUND_W-1:0] round_o,
  output type_state          state_o
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUND_MAX - 1);
  localparam logic [ROUND_W-1:0] FULL_COUNT = ROUND_W'(ROUND_MAX);

  type_perm_fsm       fsm;
  logic [ROUND_W-1:0] round_q;
  type_state          state_q;
  type_state          round_out;
  logic [ROUND_W-1:0] first_round_c;

  // Starting index 12-N; out-of-range counts fall back to the full p12.
  always_comb begin
    first_round_c = '0;
    if (rounds_i != '0 && rounds_i <= FULL_COUNT) begin
      first_round_c = FULL_COUNT - rounds_i;
    end
  end

  permutation_round u_round (
    .state       (state_q),
    .round_index (round_q),
    .next_state  (round_out)
  );

  // FSM, round counter and state register. The counter stops at the last
  // round index so it never passes 11.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm     <= IDLE;
      round_q <= '0;
      state_q <= '0;
      ready_o <= 1'b1;
      done_o  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state_q <= state_i;
            round_q <= first_round_c;
            ready_o <= 1'b0;
            fsm     <= RUN;
          end
        end
        RUN: begin
          state_q <= round_out;
          if (round_q == LAST_ROUND) begin
            done_o <= 1'b1;
            fsm    <= DONE;
          end else begin
            round_q <= round_q + ROUND_W'(1);
          end
        end
        DONE: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          fsm     <= IDLE;
        end
        default: begin
          done_o  <= 1'b0;
          ready_o <= 1'b1;
          fsm     <= IDLE;
        end
      endcase
    end
  end

  assign round_o = round_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_permutation_scheduler.sv
// tb_permutation_scheduler: scoreboard bench for permutation_scheduler.
// A reference process mirrors the acceptance rules at each rising edge and
// queues the expected result computed by an independent table-driven model;
// a monitor on the falling edge checks handshakes, round index and results.
module tb_permutation_scheduler;
  import ascon_pack::*;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [3:0]  rounds_i;
  type_state   state_i;
  logic        ready_o;
  logic        done_o;
  logic [3:0]  round_o;
  type_state   state_o;

  always #5 clock_i = ~clock_i;

  permutation_scheduler dut (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .rounds_i (rounds_i),
    .state_i  (state_i),
    .ready_o  (ready_o),
    .done_o   (done_o),
    .round_o  (round_o),
    .state_o  (state_o)
  );

  typedef struct {
    logic [319:0] result;
    int           a;
    int           n;
    int           first_r;
  } exp_t;

  exp_t         exp_q[$];
  int           cyc = 0;
  int           next_ok = 0;
  bit           armed = 1'b0;
  bit           clean = 1'b0;
  logic [319:0] last_result = '0;
  int           n_cmp = 0;
  int           n_bad = 0;

  localparam logic [319:0] IV_STATE =
    320'h80400c0600000000_8a55114d1cb6a9a2_be263d4d7aecaaff_4ed0ec0b98c529b7_c8cddf37bcd0284a;

  // ---------------- reference model ----------------
  function automatic logic [4:0] sbox_ref(input logic [4:0] v);
    logic [4:0] o;
    case (v)
      5'd0:  o = 5'h04;  5'd1:  o = 5'h0b;  5'd2:  o = 5'h1f;  5'd3:  o = 5'h14;
      5'd4:  o = 5'h1a;  5'd5:  o = 5'h15;  5'd6:  o = 5'h09;  5'd7:  o = 5'h02;
      5'd8:  o = 5'h1b;  5'd9:  o = 5'h05;  5'd10: o = 5'h08;  5'd11: o = 5'h12;
      5'd12: o = 5'h1d;  5'd13: o = 5'h03;  5'd14: o = 5'h06;  5'd15: o = 5'h1c;
      5'd16: o = 5'h1e;  5'd17: o = 5'h13;  5'd18: o = 5'h07;  5'd19: o = 5'h0e;
      5'd20: o = 5'h00;  5'd21: o = 5'h0d;  5'd22: o = 5'h11;  5'd23: o = 5'h18;
      5'd24: o = 5'h10;  5'd25: o = 5'h0c;  5'd26: o = 5'h01;  5'd27: o = 5'h19;
      5'd28: o = 5'h16;  5'd29: o = 5'h0a;  5'd30: o = 5'h0f;  default: o = 5'h17;
    endcase
    return o;
  endfunction

  function automatic logic [7:0] rc_ref(input int r);
    logic [7:0] c;
    case (r)
      0: c = 8'hf0;  1: c = 8'he1;  2: c = 8'hd2;  3: c = 8'hc3;
      4: c = 8'hb4;  5: c = 8'ha5;  6: c = 8'h96;  7: c = 8'h87;
      8: c = 8'h78;  9: c = 8'h69; 10: c = 8'h5a; default: c = 8'h4b;
    endcase
    return c;
  endfunction

  function automatic logic [63:0] rotr_ref(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] ref_round(input logic [319:0] s, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  o;
    for (int i = 0; i < 5; i++) x[i] = s[319-64*i -: 64];
    x[2][7:0] = x[2][7:0] ^ rc_ref(r);
    for (int b = 0; b < 64; b++) begin
      col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      o   = sbox_ref(col);
      for (int i = 0; i < 5; i++) y[i][b] = o[4-i];
    end
    y[0] = y[0] ^ rotr_ref(y[0], 19) ^ rotr_ref(y[0], 28);
    y[1] = y[1] ^ rotr_ref(y[1], 61) ^ rotr_ref(y[1], 39);
    y[2] = y[2] ^ rotr_ref(y[2], 1)  ^ rotr_ref(y[2], 6);
    y[3] = y[3] ^ rotr_ref(y[3], 10) ^ rotr_ref(y[3], 17);
    y[4] = y[4] ^ rotr_ref(y[4], 7)  ^ rotr_ref(y[4], 41);
    return {y[0], y[1], y[2], y[3], y[4]};
  endfunction

  function automatic int norm_rounds(input logic [3:0] r);
    return (r == 4'd0 || r > 4'd12) ? 12 : int'(r);
  endfunction

  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
    logic [319:0] v;
    v = s;
    for (int r = 12 - n; r < 12; r++) v = ref_round(v, r);
    return v;
  endfunction

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  // ---------------- expectation generator (rising edge) ----------------
  initial begin : model
    int   e;
    int   n;
    exp_t item;
    forever begin
      @(posedge clock_i);
      e = cyc + 1;
      if (reset_i) begin
        exp_q.delete();
        next_ok     = e + 1;
        armed       = 1'b1;
        clean       = 1'b1;
        last_result = '0;
      end else if (armed && start_i && e >= next_ok) begin
        n            = norm_rounds(rounds_i);
        item.result  = ref_perm(state_i, n);
        item.a       = e;
        item.n       = n;
        item.first_r = 12 - n;
        exp_q.push_back(item);
        next_ok = e + n + 2;
        clean   = 1'b0;
      end
      cyc = e;
    end
  end

  // ---------------- monitor (falling edge) ----------------
  initial begin : monitor
    bit   exp_ready;
    bit   exp_done;
    exp_t item;
    forever begin
      @(negedge clock_i);
      if (armed) begin
        exp_ready = (cyc + 1 >= next_ok);
        exp_done  = (exp_q.size() > 0) && (cyc == exp_q[0].a + exp_q[0].n);
        check("ready_o", 320'(ready_o), 320'(exp_ready));
        check("done_o", 320'(done_o), 320'(exp_done));
        if (done_o && exp_q.size() > 0) begin
          item = exp_q.pop_front();
          check("latency", 320'(cyc - item.a + 1), 320'(item.n + 1));
          check("result", state_o, item.result);
          last_result = item.result;
        end else if (exp_q.size() > 0 && cyc >= exp_q[0].a + exp_q[0].n) begin
          item = exp_q.pop_front();
          last_result = item.result;
        end
        if (exp_q.size() > 0 && cyc >= exp_q[0].a && cyc < exp_q[0].a + exp_q[0].n)
          check("round_o", 320'(round_o), 320'(exp_q[0].first_r + cyc - exp_q[0].a));
        if (exp_ready) check("idle_state_o", state_o, last_result);
        if (exp_ready && clean) check("idle_round_o", 320'(round_o), 320'(0));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_op(input logic [319:0] st, input logic [3:0] r);
    state_i  = st;
    rounds_i = r;
    start_i  = 1'b1;
    @(negedge clock_i);
    start_i  = 1'b0;
    state_i  = ~st;
    rounds_i = 4'd3;
    repeat (14) @(negedge clock_i);
  endtask

  initial begin : driver
    reset_i  = 1'b1;
    start_i  = 1'b0;
    rounds_i = 4'd0;
    state_i  = '0;
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
    repeat (20) @(negedge clock_i);

    do_op(IV_STATE, 4'd12);
    do_op(320'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0_deadbeefcafef00d, 4'd6);
    do_op(320'h1111111111111111_2222222222222222_3333333333333333_4444444444444444_5555555555555555, 4'd8);
    do_op(320'hffffffffffffffff_0000000000000000_ffffffffffffffff_0000000000000000_ffffffffffffffff, 4'd0);
    do_op(320'h0000000000000001_0000000000000002_0000000000000004_0000000000000008_0000000000000010, 4'd15);
    do_op(320'h0, 4'd1);

    // start held high, inputs changing every cycle
    start_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      state_i  = type_state'({5{64'(i + 1) * 64'h9e3779b97f4a7c15}});
      rounds_i = 4'(6 + 2 * (i % 4));
      @(negedge clock_i);
    end
    start_i = 1'b0;
    repeat (16) @(negedge clock_i);

    // reset while round 5 of a p12 is pending
    state_i  = IV_STATE;
    rounds_i = 4'd12;
    start_i  = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (5) @(negedge clock_i);
    reset_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;
    repeat (16) @(negedge clock_i);
    do_op(IV_STATE, 4'd12);

    check("pending_results", 320'(exp_q.size()), 320'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
